// File: rtl/mem_loader_if.sv
// Byte-stream input and RAM port A write bus of the boot-time program loader.
`timescale 1ns/1ps
interface mem_loader_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [7:0]            s_data;
  logic                  a_wr_en;
  logic [3:0]            a_wr_strobe;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0]           a_data_in;

  modport master (
    output s_valid, s_data,
    input  s_ready, a_wr_en, a_wr_strobe, a_addr, a_data_in
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, a_wr_en, a_wr_strobe, a_addr, a_data_in
  );
endinterface

// File: rtl/mem_loader.sv
// Boot loader: parses a length/payload/checksum byte frame, writes words to RAM
// port A and holds the core in reset until the checksum verifies.
`timescale 1ns/1ps
module mem_loader #(
  parameter int          ADDR_WIDTH = 16,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic         clk,
  input  logic         reset,
  mem_loader_if.slave  bus,
  input  logic         restart,
  output logic         core_reset_n,
  output logic         done,
  output logic         error
);
  typedef enum logic [2:0] {
    ST_LEN, ST_DATA, ST_SUM, ST_CHECK, ST_DONE, ST_ERROR
  } state_t;

  // Largest image that still fits between BASE_ADDR and the top of port A.
  localparam logic [32:0]           MAX_WORDS = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  state_t                state, state_nxt;
  logic [1:0]            byte_cnt;
  logic [31:0]           word_asm;
  logic [31:0]           n_words;
  logic [31:0]           run_sum;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [31:0]           asm_nxt;
  logic                  accept;
  logic                  last_byte;
  logic                  last_word;
  logic                  rearm;

  function automatic logic too_big(input logic [31:0] n);
    return {1'b0, n} > MAX_WORDS;
  endfunction

  assign bus.s_ready = !reset && (state inside {ST_LEN, ST_DATA, ST_SUM});
  assign accept      = bus.s_valid && bus.s_ready;
  assign last_byte   = accept && (byte_cnt == 2'd3);
  assign asm_nxt     = {bus.s_data, word_asm[31:8]};
  assign last_word   = (32'(word_idx) == n_words - 32'd1);
  assign rearm       = restart && (state == ST_DONE || state == ST_ERROR);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_LEN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LEN: begin
        if (last_byte) begin
          if (too_big(asm_nxt))     state_nxt = ST_ERROR;
          else if (asm_nxt == '0)   state_nxt = ST_SUM;
          else                      state_nxt = ST_DATA;
        end
      end
      ST_DATA:  if (last_byte && last_word) state_nxt = ST_SUM;
      ST_SUM:   if (last_byte) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = (run_sum == word_asm) ? ST_DONE : ST_ERROR;
      ST_DONE:  if (rearm) state_nxt = ST_LEN;
      ST_ERROR: if (rearm) state_nxt = ST_LEN;
      default:  state_nxt = ST_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt        <= '0;
      word_asm        <= '0;
      n_words         <= '0;
      run_sum         <= '0;
      word_idx        <= '0;
      bus.a_wr_en     <= 1'b0;
      bus.a_wr_strobe <= 4'h0;
      bus.a_addr      <= '0;
      bus.a_data_in   <= '0;
      done            <= 1'b0;
      error           <= 1'b0;
      core_reset_n    <= 1'b0;
    end else begin
      bus.a_wr_en     <= 1'b0;
      bus.a_wr_strobe <= 4'h0;
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        word_asm <= asm_nxt;
      end
      if (last_byte && state == ST_LEN) n_words <= asm_nxt;
      // Write stage: the assembled word goes out on the cycle after its 4th byte.
      if (last_byte && state == ST_DATA) begin
        bus.a_wr_en     <= 1'b1;
        bus.a_wr_strobe <= 4'hF;
        bus.a_addr      <= BASE + word_idx[ADDR_WIDTH-1:0];
        bus.a_data_in   <= asm_nxt;
        run_sum         <= run_sum + asm_nxt;
        word_idx        <= word_idx + (ADDR_WIDTH+1)'(1);
      end
      if (rearm) begin
        byte_cnt <= '0;
        word_asm <= '0;
        n_words  <= '0;
        run_sum  <= '0;
        word_idx <= '0;
      end
      // Status lags the state by one cycle but drops on the restart edge itself.
      done         <= (state == ST_DONE)  && (state_nxt == ST_DONE);
      error        <= (state == ST_ERROR) && (state_nxt == ST_ERROR);
      core_reset_n <= (state == ST_DONE)  && (state_nxt == ST_DONE);
    end
  end
endmodule

// File: tb/tb_mem_loader.sv
// Randomized frame bench for mem_loader with a queue-based reference of frames and writes.
`timescale 1ns/1ps
module tb_mem_loader;
  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic restart0 = 1'b0, restart1 = 1'b0;
  logic crn0, done0, err0, crn1, done1, err1;

  mem_loader_if #(.ADDR_WIDTH(16)) bus0 ();
  mem_loader_if #(.ADDR_WIDTH(4))  bus1 ();

  mem_loader #(.ADDR_WIDTH(16), .BASE_ADDR(32'h100)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0.slave), .restart(restart0),
    .core_reset_n(crn0), .done(done0), .error(err0)
  );

  mem_loader #(.ADDR_WIDTH(4), .BASE_ADDR(8)) u_small (
    .clk(clk), .reset(reset), .bus(bus1.slave), .restart(restart1),
    .core_reset_n(crn1), .done(done1), .error(err1)
  );

  always #5 clk = ~clk;

  int  vectors = 0;
  int  miscompares = 0;
  int  idle_strb_bad = 0;
  wr_t wr_q0[$];
  wr_t wr_q1[$];

  always @(negedge clk) begin
    if (bus0.a_wr_en) wr_q0.push_back('{32'(bus0.a_addr), bus0.a_data_in, bus0.a_wr_strobe});
    else if (bus0.a_wr_strobe !== 4'h0) idle_strb_bad++;
    if (bus1.a_wr_en) wr_q1.push_back('{32'(bus1.a_addr), bus1.a_data_in, bus1.a_wr_strobe});
    else if (bus1.a_wr_strobe !== 4'h0) idle_strb_bad++;
  end

  // Reference: frame layout and checksum straight from the frame definition.
  function automatic byte_q_t frame_bytes(input logic [31:0] n, input word_q_t w, input logic [31:0] s);
    byte_q_t q;
    for (int k = 0; k < 4; k++) q.push_back(8'(n >> (8 * k)));
    foreach (w[i]) for (int k = 0; k < 4; k++) q.push_back(8'(w[i] >> (8 * k)));
    for (int k = 0; k < 4; k++) q.push_back(8'(s >> (8 * k)));
    return q;
  endfunction

  function automatic logic [31:0] model_sum(input word_q_t w);
    logic [31:0] s = '0;
    foreach (w[i]) s = s + w[i];
    return s;
  endfunction

  function automatic word_q_t rand_words(input int n);
    word_q_t w;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    return w;
  endfunction

  task automatic send_bytes(input int sel, input byte_q_t q, input bit gaps);
    foreach (q[i]) begin
      bit   sent;
      int   tmo;
      logic v, rdy;
      sent = 1'b0;
      tmo  = 0;
      while (!sent) begin
        @(negedge clk);
        v = !(gaps && $urandom_range(0, 1) == 0);
        if (sel == 0) begin
          bus0.s_valid = v; bus0.s_data = q[i]; rdy = bus0.s_ready;
        end else begin
          bus1.s_valid = v; bus1.s_data = q[i]; rdy = bus1.s_ready;
        end
        if (v && rdy) begin
          @(posedge clk);
          sent = 1'b1;
        end else if (++tmo > 200) begin
          vectors++; miscompares++;
          $display("FAIL send_byte[%0d] sel=%0d: byte not accepted within 200 cycles", i, sel);
          bus0.s_valid = 1'b0; bus1.s_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    bus0.s_valid = 1'b0;
    bus1.s_valid = 1'b0;
  endtask

  task automatic do_restart(input int sel);
    @(negedge clk);
    if (sel == 0) restart0 = 1'b1; else restart1 = 1'b1;
    @(negedge clk);
    restart0 = 1'b0;
    restart1 = 1'b0;
  endtask

  task automatic wait_end(input int sel);
    logic fin;
    vectors++;
    for (int k = 0; k < 20; k++) begin
      fin = (sel == 0) ? (done0 | err0) : (done1 | err1);
      if (fin === 1'b1) return;
      @(negedge clk);
    end
    miscompares++;
    $display("FAIL wait_end sel=%0d: neither done nor error within 20 cycles", sel);
  endtask

  task automatic test_reset();
    bus0.s_valid = 1'b0; bus0.s_data = '0;
    bus1.s_valid = 1'b0; bus1.s_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus0.s_ready !== 1'b0 || bus1.s_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_s_ready: got %b/%b want 0/0", bus0.s_ready, bus1.s_ready);
    end
    vectors++;
    if ({bus0.a_wr_en, bus0.a_wr_strobe, bus0.a_addr, bus0.a_data_in} !== '0) begin
      miscompares++; $display("FAIL reset_port_a: en=%b strb=%h addr=%h data=%h want all 0",
                              bus0.a_wr_en, bus0.a_wr_strobe, bus0.a_addr, bus0.a_data_in);
    end
    vectors++;
    if ({crn0, done0, err0, crn1, done1, err1} !== 6'b0) begin
      miscompares++; $display("FAIL reset_status: crn/done/err=%b%b%b %b%b%b want 000 000",
                              crn0, done0, err0, crn1, done1, err1);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus0.s_ready !== 1'b1 || bus1.s_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_ready: got %b/%b want 1/1", bus0.s_ready, bus1.s_ready);
    end
  endtask

  task automatic test_basic();
    word_q_t w = '{32'h11223344, 32'hA5A5A5A5};
    logic [31:0] s = 32'hB6C7D8E9;
    wr_q0.delete();
    send_bytes(0, frame_bytes(2, w, s), 1'b0);
    vectors++;
    if (done0 !== 1'b0) begin miscompares++; $display("FAIL basic_done_t+0: got %b want 0", done0); end
    @(negedge clk);
    vectors++;
    if (done0 !== 1'b0) begin miscompares++; $display("FAIL basic_done_t+1: got %b want 0", done0); end
    @(negedge clk);
    vectors++;
    if ({done0, crn0, err0, bus0.s_ready} !== {1'b1, model_sum(w) == s, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL basic_done_t+2: done/crn/err/rdy=%b%b%b%b want 1100",
                              done0, crn0, err0, bus0.s_ready);
    end
    vectors++;
    if (wr_q0.size() !== 2) begin miscompares++; $display("FAIL basic_wr_count: got %0d want 2", wr_q0.size()); end
    foreach (wr_q0[i]) begin
      vectors++;
      if (i < 2 && {wr_q0[i].addr, wr_q0[i].data, wr_q0[i].strb} !== {32'h100 + 32'(i), w[i], 4'hF}) begin
        miscompares++; $display("FAIL basic_wr[%0d]: addr=%h data=%h strb=%h want %h %h F",
                                i, wr_q0[i].addr, wr_q0[i].data, wr_q0[i].strb, 32'h100 + i, w[i]);
      end
    end
    do_restart(0);
    vectors++;
    if ({done0, crn0, err0, bus0.s_ready} !== 4'b0001) begin
      miscompares++; $display("FAIL basic_restart: done/crn/err/rdy=%b%b%b%b want 0001",
                              done0, crn0, err0, bus0.s_ready);
    end
  endtask

  task automatic test_zero();
    word_q_t w;
    wr_q0.delete();
    send_bytes(0, frame_bytes(0, w, 32'h0), 1'b0);
    wait_end(0);
    @(negedge clk);
    vectors++;
    if (wr_q0.size() !== 0) begin miscompares++; $display("FAIL zero_wr_count: got %0d want 0", wr_q0.size()); end
    vectors++;
    if ({done0, crn0, err0} !== 3'b110) begin
      miscompares++; $display("FAIL zero_status: done/crn/err=%b%b%b want 110", done0, crn0, err0);
    end
    do_restart(0);
  endtask

  task automatic test_bad_sum();
    word_q_t w = '{32'h11223344, 32'hA5A5A5A5};
    word_q_t w2;
    wr_q0.delete();
    send_bytes(0, frame_bytes(2, w, 32'h0), 1'b0);
    wait_end(0);
    repeat (3) @(negedge clk);
    vectors++;
    if ({done0, crn0, err0, bus0.s_ready} !== 4'b0010) begin
      miscompares++; $display("FAIL badsum_status: done/crn/err/rdy=%b%b%b%b want 0010",
                              done0, crn0, err0, bus0.s_ready);
    end
    vectors++;
    if (wr_q0.size() !== 2 || wr_q0[0].data !== w[0] || wr_q0[1].data !== w[1]) begin
      miscompares++; $display("FAIL badsum_writes: count=%0d want 2 words %h %h", wr_q0.size(), w[0], w[1]);
    end
    do_restart(0);
    w2 = rand_words(3);
    send_bytes(0, frame_bytes(3, w2, model_sum(w2)), 1'b0);
    wait_end(0);
    @(negedge clk);
    vectors++;
    if ({done0, crn0, err0} !== 3'b110) begin
      miscompares++; $display("FAIL badsum_reload: done/crn/err=%b%b%b want 110", done0, crn0, err0);
    end
    do_restart(0);
  endtask

  task automatic test_gaps();
    for (int it = 0; it < 6; it++) begin
      word_q_t     w;
      logic [31:0] s;
      logic        ok;
      if (it == 0) begin
        w = '{32'h11223344, 32'hA5A5A5A5};
        s = 32'hB6C7D8E9;
      end else begin
        w = rand_words($urandom_range(1, 6));
        s = model_sum(w);
        if ($urandom_range(0, 3) == 0) s = s ^ (32'h1 << $urandom_range(0, 31));
      end
      ok = (s == model_sum(w));
      wr_q0.delete();
      send_bytes(0, frame_bytes(32'(w.size()), w, s), 1'b1);
      wait_end(0);
      @(negedge clk);
      vectors++;
      if ({done0, err0, crn0} !== {ok, !ok, ok}) begin
        miscompares++; $display("FAIL gaps[%0d]_status: done/err/crn=%b%b%b want %b%b%b",
                                it, done0, err0, crn0, ok, !ok, ok);
      end
      vectors++;
      if (wr_q0.size() !== w.size()) begin
        miscompares++; $display("FAIL gaps[%0d]_wr_count: got %0d want %0d", it, wr_q0.size(), w.size());
      end
      foreach (wr_q0[i]) begin
        vectors++;
        if (i < w.size() && {wr_q0[i].addr, wr_q0[i].data, wr_q0[i].strb} !== {32'h100 + 32'(i), w[i], 4'hF}) begin
          miscompares++; $display("FAIL gaps[%0d]_wr[%0d]: addr=%h data=%h strb=%h want %h %h F",
                                  it, i, wr_q0[i].addr, wr_q0[i].data, wr_q0[i].strb, 32'h100 + i, w[i]);
        end
      end
      do_restart(0);
    end
  endtask

  task automatic test_oversize();
    word_q_t w = rand_words(8);
    byte_q_t hdr = '{8'd9, 8'd0, 8'd0, 8'd0};
    wr_q1.delete();
    send_bytes(1, frame_bytes(8, w, model_sum(w)), 1'b0);
    wait_end(1);
    @(negedge clk);
    vectors++;
    if ({done1, err1, crn1} !== 3'b101) begin
      miscompares++; $display("FAIL fit8_status: done/err/crn=%b%b%b want 101", done1, err1, crn1);
    end
    vectors++;
    if (wr_q1.size() !== 8) begin miscompares++; $display("FAIL fit8_wr_count: got %0d want 8", wr_q1.size()); end
    foreach (wr_q1[i]) begin
      vectors++;
      if (i < 8 && {wr_q1[i].addr, wr_q1[i].data} !== {32'd8 + 32'(i), w[i]}) begin
        miscompares++; $display("FAIL fit8_wr[%0d]: addr=%h data=%h want %h %h",
                                i, wr_q1[i].addr, wr_q1[i].data, 8 + i, w[i]);
      end
    end
    do_restart(1);
    wr_q1.delete();
    send_bytes(1, hdr, 1'b0);
    vectors++;
    if (bus1.s_ready !== 1'b0) begin miscompares++; $display("FAIL over_ready: got %b want 0", bus1.s_ready); end
    wait_end(1);
    repeat (4) begin
      @(negedge clk);
      bus1.s_valid = 1'b1;
      bus1.s_data  = 8'hFF;
    end
    @(negedge clk);
    bus1.s_valid = 1'b0;
    vectors++;
    if ({err1, done1, crn1, bus1.s_ready} !== 4'b1000) begin
      miscompares++; $display("FAIL over_status: err/done/crn/rdy=%b%b%b%b want 1000",
                              err1, done1, crn1, bus1.s_ready);
    end
    vectors++;
    if (wr_q1.size() !== 0) begin miscompares++; $display("FAIL over_writes: got %0d want 0", wr_q1.size()); end
    vectors++;
    if (idle_strb_bad !== 0) begin
      miscompares++; $display("FAIL idle_strobe: %0d cycles with strobe set while a_wr_en=0, want 0", idle_strb_bad);
    end
  endtask

  task automatic test_reset_mid();
    word_q_t w = rand_words(2);
    byte_q_t full = frame_bytes(2, w, model_sum(w));
    byte_q_t part = full[0:9];
    word_q_t w3;
    wr_q0.delete();
    send_bytes(0, part, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (wr_q0.size() !== 1 || wr_q0[0].addr !== 32'h100 || wr_q0[0].data !== w[0]) begin
      miscompares++; $display("FAIL midreset_writes: count=%0d want 1 write (100,%h)", wr_q0.size(), w[0]);
    end
    vectors++;
    if ({bus0.a_wr_en, bus0.a_wr_strobe, bus0.a_addr, bus0.a_data_in, crn0, done0, err0, bus0.s_ready} !== '0) begin
      miscompares++; $display("FAIL midreset_outputs: en=%b addr=%h data=%h crn/done/err/rdy=%b%b%b%b want all 0",
                              bus0.a_wr_en, bus0.a_addr, bus0.a_data_in, crn0, done0, err0, bus0.s_ready);
    end
    reset = 1'b0;
    wr_q0.delete();
    w3 = rand_words(3);
    send_bytes(0, frame_bytes(3, w3, model_sum(w3)), 1'b0);
    wait_end(0);
    @(negedge clk);
    vectors++;
    if ({done0, err0, crn0} !== 3'b101 || wr_q0.size() !== 3) begin
      miscompares++; $display("FAIL midreset_reload: done/err/crn=%b%b%b writes=%0d want 101 and 3",
                              done0, err0, crn0, wr_q0.size());
    end
    vectors++;
    if (wr_q0.size() > 0 && {wr_q0[0].addr, wr_q0[0].data} !== {32'h100, w3[0]}) begin
      miscompares++; $display("FAIL midreset_first_addr: addr=%h data=%h want 100 %h",
                              wr_q0[0].addr, wr_q0[0].data, w3[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_bad_sum();
    test_gaps();
    test_oversize();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within 500 us");
    $fatal(1, "watchdog expired");
  end
endmodule
